dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the memory size in 32-bit words; it SHALL be a power of two.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 busReq  input  1  requester asserts for a transfer.
REQ-005 busWe  input  1  1 = store, 0 = load.
REQ-006 busAddr  input  32  byte address.
REQ-007 busWData  input  32  store data, right-justified.
REQ-008 busFunct3  input  3  access size/sign (RV32I load/store funct3).
REQ-009 busReady  output  1  one-cycle completion strobe.
REQ-010 busRData  output  32  load result, valid while busReady=1.
REQ-011 busErr  output  1  transfer rejected, valid while busReady=1.

Function
REQ-012 FSM SHALL have two states, IDLE and ACCESS.
REQ-013 IDLE with busReq=1 SHALL, at the rising edge, capture busWe, busAddr, busWData and busFunct3, then move to ACCESS; IDLE with busReq=0 SHALL remain in IDLE.
REQ-014 ACCESS SHALL drive busReady=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-015 busReq SHALL be ignored in ACCESS; a request still held in the following IDLE cycle SHALL start a new transfer, giving at most one transfer per 2 cycles.
REQ-016 Latency: request sampled at edge N; busReady, busRData and busErr are valid in cycle N+1.
REQ-017 Word index SHALL be busAddr[log2(DEPTH)+1:2]; any set bit in busAddr[31:log2(DEPTH)+2] SHALL be out of range.
REQ-018 Valid load funct3 values: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; valid store funct3 values: 0 SB, 1 SH, 2 SW; all other values SHALL be errors.
REQ-019 Misalignment SHALL be an error: half access with addr[0]=1, or word access with addr[1:0]≠0.
REQ-020 Error transfers (out of range, misaligned, or illegal funct3) SHALL assert busErr=1 with busReady, drive busRData=0 and leave memory unmodified.
REQ-021 SB SHALL write wdata[7:0] into byte lane addr[1:0]; SH SHALL write wdata[15:0] into half lane addr[1]; SW SHALL write all 32 bits; other lanes SHALL be preserved.
REQ-022 A store SHALL commit at the rising edge that ends ACCESS; busRData SHALL be 0 for stores.
REQ-023 Loads SHALL extract the addressed byte or half and sign-extend it (LB, LH) or zero-extend it (LBU, LHU); LW SHALL return the full word.
REQ-024 A load issued in the IDLE cycle right after a store to the same word SHALL return the updated data.
REQ-025 Outside ACCESS: busReady=0, busErr=0, busRData=0.

Reset
REQ-026 Reset SHALL force IDLE and busReady=0, busErr=0, busRData=0, and clear the captured request registers to 0.
REQ-027 Reset asserted during ACCESS SHALL abort the transfer: no store commits and no busReady is issued.
REQ-028 Memory array contents SHALL NOT be reset.

Structure
REQ-029 The shared defines package SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum.
REQ-030 One combinational sub-module, dmem_lane_align, SHALL perform store-lane merge and load extract/extend; FSM and array stay in dmem_responder.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> busReady in the cycle after each request; load busRData=0xDEADBEEF, busErr=0.
REQ-032 After REQ-031, SB addr 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
REQ-033 LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; SH 0x13 -> busErr=1 and LW 0x10 unchanged.
REQ-034 SW 0x0000_0400 (DEPTH=256), LW 0x0000_0401, and load funct3=3 -> each busErr=1, busRData=0, no memory change.
REQ-035 busReq held high for 6 cycles with LW -> exactly 3 busReady pulses, on cycles 2, 4 and 6.
REQ-036 Reset pulsed in the ACCESS cycle of SW 0x20 data 0x12345678 -> no busReady; a later LW 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, the FSM state type and the request fault check.
package dmem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Illegal funct3 for the direction, or an address not aligned to the access size.
    function automatic logic access_fault(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end else begin
            illegal = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                        funct3 == F3_LBU || funct3 == F3_LHU);
        end
        case (funct3[1:0])
            2'd1:    misaligned = addr_lo[0];
            2'd2:    misaligned = (addr_lo != 2'd0);
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: merges store data into the addressed byte/half lane
// and extracts/extends the addressed byte/half for loads.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        store_word = word;
        load_data  = 32'd0;
        sel_half   = addr_lo[1] ? word[31:16] : word[15:0];
        case (addr_lo)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase

        case (funct3)
            F3_SB: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_SH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            F3_SW:   store_word = wdata;
            default: store_word = word;
        endcase

        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'd0, sel_byte};
            F3_LHU:  load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory slave: captures a request in IDLE, answers it with a
// one-cycle ready strobe in ACCESS, and commits stores at the end of ACCESS.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [2:0]  busFunct3,
    output logic        busReady,
    output logic [31:0] busRData,
    output logic        busErr
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    state_t      state_next;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_we;
    logic        fault;
    logic [31:0] store_word;
    logic [31:0] load_data;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] word_idx;

    assign word_idx = req_addr[AW+1:2];
    assign fault    = (|req_addr[31:AW+2]) || access_fault(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_we     <= 1'b0;
            req_addr   <= 32'd0;
            req_wdata  <= 32'd0;
            req_funct3 <= 3'd0;
        end else if (state == IDLE && busReq) begin
            req_we     <= busWe;
            req_addr   <= busAddr;
            req_wdata  <= busWData;
            req_funct3 <= busFunct3;
        end
    end

    // Outputs are only live in ACCESS; faulted transfers neither read nor write.
    always_comb begin
        state_next = state;
        busReady   = 1'b0;
        busErr     = 1'b0;
        busRData   = 32'd0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (busReq) state_next = ACCESS;
            end
            ACCESS: begin
                state_next = IDLE;
                busReady   = 1'b1;
                busErr     = fault;
                if (!fault) begin
                    if (req_we) mem_we = 1'b1;
                    else        busRData = load_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The array has no reset; an asynchronous reset drops the state out of
    // ACCESS first, so an aborted store never reaches this edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= store_word;
        end
    end

    dmem_lane_align u_lane_align (
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .word       (mem[word_idx]),
        .wdata      (req_wdata),
        .store_word (store_word),
        .load_data  (load_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a byte-level memory model predicts every response,
// and directed transfers pin the model with hand-computed results.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busReq = 1'b0;
    logic        busWe = 1'b0;
    logic [31:0] busAddr = 32'd0;
    logic [31:0] busWData = 32'd0;
    logic [2:0]  busFunct3 = 3'd0;
    logic        busReady;
    logic [31:0] busRData;
    logic        busErr;

    int checks = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWData  (busWData),
        .busFunct3 (busFunct3),
        .busReady  (busReady),
        .busRData  (busRData),
        .busErr    (busErr)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a word array with known-flags, answering each accepted
    // request from the access rules; stores are held until the edge ending the reply.
    logic [31:0]     model_mem [DEPTH];
    bit              known [DEPTH];
    bit              m_busy, m_pend, m_pend_known;
    int              m_pend_idx;
    logic [31:0]     m_pend_word;
    logic            exp_ready = 1'b0, exp_err = 1'b0;
    logic [31:0]     exp_rdata = 32'd0;
    bit              exp_known = 1'b1;
    longint unsigned a, mask, v, word;
    int              f3, nbytes, idx, shift;
    bit              legal;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_pend = 0;
            exp_ready = 0; exp_err = 0; exp_rdata = 0; exp_known = 1;
        end else begin
            if (m_pend) begin
                model_mem[m_pend_idx] = m_pend_word;
                known[m_pend_idx] = m_pend_known;
                m_pend = 0;
            end
            exp_ready = 0; exp_err = 0; exp_rdata = 0; exp_known = 1;
            if (m_busy) begin
                m_busy = 0;
            end else if (busReq) begin
                m_busy = 1;
                exp_ready = 1;
                a = longint'(busAddr);
                f3 = int'(busFunct3);
                nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
                legal = busWe ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
                if (!legal || a >= longint'(DEPTH * 4) || (a % longint'(nbytes)) != 0) begin
                    exp_err = 1;
                end else begin
                    idx = int'(a / 4);
                    shift = int'(a % 4) * 8;
                    mask = (64'd1 << (nbytes * 8)) - 1;
                    word = longint'(model_mem[idx]);
                    if (busWe) begin
                        m_pend = 1;
                        m_pend_idx = idx;
                        m_pend_word = 32'((word & ~(mask << shift)) |
                                          ((longint'(busWData) & mask) << shift));
                        m_pend_known = known[idx] || nbytes == 4;
                    end else begin
                        v = (word >> shift) & mask;
                        if (f3 < 4 && nbytes < 4 && v[nbytes*8-1]) v = v | ~mask;
                        exp_rdata = 32'(v);
                        exp_known = known[idx];
                    end
                end
            end
        end
    end

    // Every cycle out of reset the DUT must agree with the model.
    always @(negedge clk) begin
        if (!reset) begin
            compare("cycle_ready", 32'(busReady), 32'(exp_ready));
            compare("cycle_err", 32'(busErr), 32'(exp_err));
            if (exp_known) compare("cycle_rdata", busRData, exp_rdata);
        end
    end

    task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] funct3);
        busReq = 1'b1;
        busWe = we;
        busAddr = addr;
        busWData = wdata;
        busFunct3 = funct3;
        @(posedge clk);
        @(negedge clk);
        busReq = 1'b0;
    endtask

    task automatic check_output(input string name, input logic exp_e, input logic [31:0] exp_d);
        compare({name, "_ready"}, 32'(busReady), 32'd1);
        compare({name, "_err"}, 32'(busErr), 32'(exp_e));
        compare({name, "_rdata"}, busRData, exp_d);
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [5:0] pulses;

    initial begin
        repeat (2) @(negedge clk);
        compare("reset_ready", 32'(busReady), 32'd0);
        compare("reset_err", 32'(busErr), 32'd0);
        compare("reset_rdata", busRData, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        apply_stimulus(1, 32'h10, 32'hDEADBEEF, 3'd2); check_output("sw_10", 0, 32'h0);
        apply_stimulus(0, 32'h10, 32'h0, 3'd2);        check_output("lw_10", 0, 32'hDEADBEEF);
        apply_stimulus(1, 32'h11, 32'h55, 3'd0);       check_output("sb_11", 0, 32'h0);
        apply_stimulus(0, 32'h10, 32'h0, 3'd2);        check_output("lw_10_sb", 0, 32'hDEAD55EF);
        apply_stimulus(0, 32'h13, 32'h0, 3'd0);        check_output("lb_13", 0, 32'hFFFFFFDE);
        apply_stimulus(0, 32'h13, 32'h0, 3'd4);        check_output("lbu_13", 0, 32'h000000DE);
        apply_stimulus(0, 32'h12, 32'h0, 3'd1);        check_output("lh_12", 0, 32'hFFFFDEAD);
        apply_stimulus(0, 32'h12, 32'h0, 3'd5);        check_output("lhu_12", 0, 32'h0000DEAD);
        apply_stimulus(1, 32'h13, 32'hFFFF, 3'd1);     check_output("sh_13_misalign", 1, 32'h0);
        apply_stimulus(0, 32'h10, 32'h0, 3'd2);        check_output("lw_10_after_err", 0, 32'hDEAD55EF);

        apply_stimulus(1, 32'h0, 32'h01020304, 3'd2);  check_output("sw_0", 0, 32'h0);
        apply_stimulus(1, 32'h400, 32'hFFFFFFFF, 3'd2);check_output("sw_400_range", 1, 32'h0);
        apply_stimulus(0, 32'h401, 32'h0, 3'd2);       check_output("lw_401_misalign", 1, 32'h0);
        apply_stimulus(0, 32'h0, 32'h0, 3'd3);         check_output("load_f3_3", 1, 32'h0);
        apply_stimulus(1, 32'h0, 32'h0, 3'd4);         check_output("store_f3_4", 1, 32'h0);
        apply_stimulus(0, 32'h0, 32'h0, 3'd2);         check_output("lw_0_unchanged", 0, 32'h01020304);

        apply_stimulus(1, 32'h14, 32'h0, 3'd2);        check_output("sw_14", 0, 32'h0);
        apply_stimulus(1, 32'h16, 32'h1234ABCD, 3'd1); check_output("sh_16", 0, 32'h0);
        apply_stimulus(1, 32'h17, 32'h80, 3'd0);       check_output("sb_17", 0, 32'h0);
        apply_stimulus(1, 32'h15, 32'h7F, 3'd0);       check_output("sb_15", 0, 32'h0);
        apply_stimulus(0, 32'h14, 32'h0, 3'd2);        check_output("lw_14", 0, 32'h80CD7F00);
        apply_stimulus(0, 32'h17, 32'h0, 3'd0);        check_output("lb_17", 0, 32'hFFFFFF80);
        apply_stimulus(0, 32'h15, 32'h0, 3'd0);        check_output("lb_15", 0, 32'h0000007F);
        apply_stimulus(0, 32'h14, 32'h0, 3'd1);        check_output("lh_14", 0, 32'h00007F00);

        apply_stimulus(1, 32'h3FC, 32'h11223344, 3'd2);check_output("sw_3fc", 0, 32'h0);
        apply_stimulus(0, 32'h3FE, 32'h0, 3'd1);       check_output("lh_3fe", 0, 32'h00001122);

        apply_stimulus(1, 32'h20, 32'hCAFEF00D, 3'd2); check_output("sw_20", 0, 32'h0);
        busReq = 1'b1; busWe = 1'b1; busAddr = 32'h20; busWData = 32'h12345678; busFunct3 = 3'd2;
        @(posedge clk);
        #2 reset = 1'b1;
        busReq = 1'b0;
        #1 compare("abort_ready_during_reset", 32'(busReady), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        compare("abort_ready", 32'(busReady), 32'd0);
        compare("abort_err", 32'(busErr), 32'd0);
        apply_stimulus(0, 32'h20, 32'h0, 3'd2);        check_output("lw_20_after_abort", 0, 32'hCAFEF00D);

        busReq = 1'b1; busWe = 1'b0; busAddr = 32'h10; busFunct3 = 3'd2;
        for (int i = 0; i < 6; i++) begin
            pulses[i] = busReady;
            if (busReady) compare("burst_rdata", busRData, 32'hDEAD55EF);
            if (i == 5) busReq = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        compare("burst_pattern", 32'(pulses), 32'h2A);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
